// File: rtl/pcpi_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : pcpi_cmd_master
// Function : PCPI initiator; issues a streamed command to a coprocessor and
//            returns its result (or a timeout error) on a response stream.
// Revision : 1.0 - initial release
// ============================================================================
module pcpi_cmd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [31:0]           cmd_insn,
  input  logic [DATA_WIDTH-1:0] cmd_rs1,
  input  logic [DATA_WIDTH-1:0] cmd_rs2,
  output logic                  pcpi_valid,
  output logic [31:0]           pcpi_insn,
  output logic [DATA_WIDTH-1:0] pcpi_rs1,
  output logic [DATA_WIDTH-1:0] pcpi_rs2,
  input  logic                  pcpi_wr,
  input  logic [DATA_WIDTH-1:0] pcpi_rd,
  input  logic                  pcpi_wait,
  input  logic                  pcpi_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rd,
  output logic                  rsp_wr,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int                 c_TIMER_W    = $clog2(TIMEOUT) + 1;
  localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [c_TIMER_W-1:0]    r_timer, w_timer_nxt;
  logic                    r_cmd_ready, w_cmd_ready_nxt;
  logic                    r_pcpi_valid, w_pcpi_valid_nxt;
  logic [31:0]             r_pcpi_insn, w_pcpi_insn_nxt;
  logic [DATA_WIDTH-1:0]   r_pcpi_rs1, w_pcpi_rs1_nxt;
  logic [DATA_WIDTH-1:0]   r_pcpi_rs2, w_pcpi_rs2_nxt;
  logic                    r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0]   r_rsp_rd, w_rsp_rd_nxt;
  logic                    r_rsp_wr, w_rsp_wr_nxt;
  logic                    r_rsp_err, w_rsp_err_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_cmd_ready  <= 1'b0;
      r_pcpi_valid <= 1'b0;
      r_pcpi_insn  <= '0;
      r_pcpi_rs1   <= '0;
      r_pcpi_rs2   <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rd     <= '0;
      r_rsp_wr     <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_cmd_ready  <= w_cmd_ready_nxt;
      r_pcpi_valid <= w_pcpi_valid_nxt;
      r_pcpi_insn  <= w_pcpi_insn_nxt;
      r_pcpi_rs1   <= w_pcpi_rs1_nxt;
      r_pcpi_rs2   <= w_pcpi_rs2_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_rd     <= w_rsp_rd_nxt;
      r_rsp_wr     <= w_rsp_wr_nxt;
      r_rsp_err    <= w_rsp_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = r_timer;
    w_cmd_ready_nxt  = r_cmd_ready;
    w_pcpi_valid_nxt = r_pcpi_valid;
    w_pcpi_insn_nxt  = r_pcpi_insn;
    w_pcpi_rs1_nxt   = r_pcpi_rs1;
    w_pcpi_rs2_nxt   = r_pcpi_rs2;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_rd_nxt     = r_rsp_rd;
    w_rsp_wr_nxt     = r_rsp_wr;
    w_rsp_err_nxt    = r_rsp_err;

    case (r_state)
      S_IDLE: begin
        // cmd_ready comes up on the first edge after reset release
        w_cmd_ready_nxt = 1'b1;
        if (cmd_valid && r_cmd_ready) begin
          w_pcpi_insn_nxt  = cmd_insn;
          w_pcpi_rs1_nxt   = cmd_rs1;
          w_pcpi_rs2_nxt   = cmd_rs2;
          w_timer_nxt      = '0;
          w_cmd_ready_nxt  = 1'b0;
          w_pcpi_valid_nxt = 1'b1;
          w_state_nxt      = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // completion outranks both wait and an expiring timer
        if (pcpi_ready) begin
          w_rsp_rd_nxt     = pcpi_rd;
          w_rsp_wr_nxt     = pcpi_wr;
          w_rsp_err_nxt    = 1'b0;
          w_pcpi_valid_nxt = 1'b0;
          w_rsp_valid_nxt  = 1'b1;
          w_state_nxt      = S_RESP;
        end else if (pcpi_wait) begin
          w_timer_nxt = '0;
        end else if (r_timer == c_TIMER_LAST) begin
          w_rsp_rd_nxt     = '0;
          w_rsp_wr_nxt     = 1'b0;
          w_rsp_err_nxt    = 1'b1;
          w_pcpi_valid_nxt = 1'b0;
          w_rsp_valid_nxt  = 1'b1;
          w_state_nxt      = S_RESP;
        end else if (!(&r_timer)) begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign cmd_ready  = r_cmd_ready;
  assign pcpi_valid = r_pcpi_valid;
  assign pcpi_insn  = r_pcpi_insn;
  assign pcpi_rs1   = r_pcpi_rs1;
  assign pcpi_rs2   = r_pcpi_rs2;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rd     = r_rsp_rd;
  assign rsp_wr     = r_rsp_wr;
  assign rsp_err    = r_rsp_err;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pcpi_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcpi_cmd_master
// Function : directed testbench for pcpi_cmd_master with a behavioural responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcpi_cmd_master;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [31:0]   cmd_insn;
  logic [DW-1:0] cmd_rs1, cmd_rs2;
  logic          pcpi_valid;
  logic [31:0]   pcpi_insn;
  logic [DW-1:0] pcpi_rs1, pcpi_rs2;
  logic          pcpi_wr;
  logic [DW-1:0] pcpi_rd;
  logic          pcpi_wait, pcpi_ready;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rd;
  logic          rsp_wr, rsp_err, busy;

  int vectors    = 0;
  int miscompares = 0;

  pcpi_cmd_master #(.DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_insn(cmd_insn),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1),
    .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
    .rsp_wr(rsp_wr), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // carry-less (GF(2)[x]) product, as a Galois responder would return
  function automatic logic [DW-1:0] clmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] p = '0;
    for (int i = 0; i < DW; i++) if (b[i]) p ^= (a << i);
    return p;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // presents a command for one edge; caller is at a negedge in IDLE with cmd_ready=1
  task automatic issue(input logic [31:0] insn, input logic [DW-1:0] a, input logic [DW-1:0] b);
    cmd_valid = 1'b1; cmd_insn = insn; cmd_rs1 = a; cmd_rs2 = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 0; cmd_insn = 0; cmd_rs1 = 0; cmd_rs2 = 0;
    pcpi_wr = 0; pcpi_rd = 0; pcpi_wait = 0; pcpi_ready = 0; rsp_ready = 0;
    repeat (3) tick();
    vectors++;
    if ({cmd_ready, pcpi_valid, rsp_valid, busy, rsp_err, rsp_wr} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {cmd_ready, pcpi_valid, rsp_valid, busy, rsp_err, rsp_wr});
    end
    reset = 1'b0;
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_release_no_edge: cmd_ready got %b expected 0", cmd_ready);
    end
    tick();
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_first_edge: cmd_ready/busy got %b%b expected 10", cmd_ready, busy);
    end
  endtask

  task automatic test_galois();
    issue(32'h0000_100B, 32'h1F, 32'h3FC);
    vectors++;
    if (pcpi_valid !== 1'b1 || pcpi_rs1 !== 32'h1F || pcpi_rs2 !== 32'h3FC ||
        pcpi_insn !== 32'h0000_100B || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL galois_issue: valid=%b insn=%h rs1=%h rs2=%h cmd_ready=%b expected 1 0000100b 1f 3fc 0",
               pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, cmd_ready);
    end
    pcpi_wait = 1'b1;
    tick();
    pcpi_wait = 1'b0; pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = clmul(pcpi_rs1, pcpi_rs2);
    tick();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0;
    vectors++;
    if (rsp_valid !== 1'b1 || pcpi_valid !== 1'b0 || rsp_rd !== 32'h0000_2BD4 ||
        rsp_wr !== 1'b1 || rsp_err !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL galois_resp: rsp_valid=%b pcpi_valid=%b rd=%h wr=%b err=%b busy=%b expected 1 0 00002bd4 1 0 1",
               rsp_valid, pcpi_valid, rsp_rd, rsp_wr, rsp_err, busy);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL galois_handshake: rsp_valid=%b cmd_ready=%b busy=%b expected 0 1 0",
               rsp_valid, cmd_ready, busy);
    end
  endtask

  task automatic test_long_wait();
    int high = 0;
    issue(32'h1, 32'h11, 32'h22);
    pcpi_wait = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (pcpi_valid === 1'b1) high++;
      tick();
    end
    if (pcpi_valid === 1'b1) high++;
    pcpi_wait = 1'b0; pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h1234_5678;
    tick();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0;
    vectors++;
    if (high != 41 || pcpi_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL long_wait_valid: high cycles %0d valid_after=%b expected 41 0", high, pcpi_valid);
    end
    vectors++;
    if (rsp_err !== 1'b0 || rsp_rd !== 32'h1234_5678 || rsp_wr !== 1'b1) begin
      miscompares++;
      $display("FAIL long_wait_resp: err=%b rd=%h wr=%b expected 0 12345678 1", rsp_err, rsp_rd, rsp_wr);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int high = 0;
    issue(32'h2, 32'h33, 32'h44);
    for (int i = 0; i < 40 && pcpi_valid === 1'b1; i++) begin
      high++;
      tick();
    end
    vectors++;
    if (high != 16) begin
      miscompares++; $display("FAIL timeout_valid_len: got %0d cycles expected 16", high);
    end
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rd !== '0 || rsp_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_resp: valid=%b err=%b rd=%h wr=%b expected 1 1 00000000 0",
               rsp_valid, rsp_err, rsp_rd, rsp_wr);
    end
    // late completion while in RESP must not disturb the captured response
    pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hDEAD_BEEF;
    tick();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0;
    vectors++;
    if (rsp_err !== 1'b1 || rsp_rd !== '0 || rsp_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL resp_ignores_pcpi: err=%b rd=%h wr=%b expected 1 00000000 0", rsp_err, rsp_rd, rsp_wr);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    issue(32'h3, 32'hA5A5, 32'h5A5A);
    pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h0000_A5A5;
    tick();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rd !== 32'h0000_A5A5) begin
      miscompares++;
      $display("FAIL ready_first_cycle: valid=%b rd=%h expected 1 0000a5a5", rsp_valid, rsp_rd);
    end
    cmd_valid = 1'b1; cmd_insn = 32'h4; cmd_rs1 = 32'hBBBB_0001; cmd_rs2 = 32'hCCCC_0002;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_rd !== 32'h0000_A5A5 || rsp_wr !== 1'b1 ||
          cmd_ready !== 1'b0 || pcpi_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: valid=%b rd=%h wr=%b cmd_ready=%b pcpi_valid=%b expected 1 0000a5a5 1 0 0",
                 i, rsp_valid, rsp_rd, rsp_wr, cmd_ready, pcpi_valid);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vectors++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || pcpi_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL handshake_no_accept: cmd_ready=%b rsp_valid=%b pcpi_valid=%b expected 1 0 0",
               cmd_ready, rsp_valid, pcpi_valid);
    end
    tick();
    cmd_valid = 1'b0;
    vectors++;
    if (pcpi_valid !== 1'b1 || pcpi_rs1 !== 32'hBBBB_0001 || pcpi_rs2 !== 32'hCCCC_0002) begin
      miscompares++;
      $display("FAIL second_accept: valid=%b rs1=%h rs2=%h expected 1 bbbb0001 cccc0002",
               pcpi_valid, pcpi_rs1, pcpi_rs2);
    end
    pcpi_ready = 1'b1; pcpi_rd = 32'h77; tick(); pcpi_ready = 1'b0; pcpi_rd = '0;
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_ready_at_expiry();
    issue(32'h5, 32'h55, 32'h66);
    repeat (15) tick();
    vectors++;
    if (pcpi_valid !== 1'b1) begin
      miscompares++; $display("FAIL pre_expiry_valid: got %b expected 1", pcpi_valid);
    end
    pcpi_ready = 1'b1; pcpi_wr = 1'b0; pcpi_rd = 32'hCAFE_F00D;
    tick();
    pcpi_ready = 1'b0; pcpi_rd = '0;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_wr !== 1'b0 || rsp_rd !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL ready_wins_expiry: valid=%b err=%b wr=%b rd=%h expected 1 0 0 cafef00d",
               rsp_valid, rsp_err, rsp_wr, rsp_rd);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_issue();
    issue(32'h6, 32'h99, 32'h88);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (pcpi_valid !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: pcpi_valid=%b rsp_valid=%b busy=%b expected 0 0 0",
               pcpi_valid, rsp_valid, busy);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || pcpi_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset: cmd_ready=%b busy=%b rsp_valid=%b pcpi_valid=%b expected 1 0 0 0",
               cmd_ready, busy, rsp_valid, pcpi_valid);
    end
  endtask

  initial begin
    test_reset();
    test_galois();
    test_long_wait();
    test_timeout();
    test_back_to_back();
    test_ready_at_expiry();
    test_reset_mid_issue();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
